// File: rtl/p2s_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : p2s_pkg
//  Purpose   : Shared state encoding for the parallel-to-serial converter.
//  Contents  : p2s_state_t - IDLE (shifter empty) / SHIFT (shifter loaded)
//  Revision  : 1.0 - initial release
// ============================================================================
package p2s_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_t;

endpackage : p2s_pkg
`default_nettype wire

// File: rtl/parallel_to_serial.sv
`default_nettype none
// ============================================================================
//  Module    : parallel_to_serial
//  Purpose   : Converts width-bit parallel words into an LSB-first serial
//              stream with valid/ready handshakes on both sides. A shifter
//              plus one holding register allow back-to-back words with no
//              idle cycle between them.
//  Ports     :
//    clk            in   clock, all state changes on rising edge
//    rst_n          in   asynchronous active-low reset
//    parallel_valid in   upstream word valid
//    parallel_data  in   upstream word [width-1:0]
//    parallel_ready out  a word can be accepted this cycle (registered)
//    serial_valid   out  serial_data holds a valid bit
//    serial_data    out  current serial bit
//    serial_last    out  current bit is bit width-1 of its word
//    serial_ready   in   downstream accepts the bit this cycle
//    busy           out  shifter or holding register occupied
//  Revision  : 1.0 - initial release
// ============================================================================
module parallel_to_serial
  import p2s_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  output logic             serial_last,
  input  logic             serial_ready,
  output logic             busy
);

  localparam int                 c_cnt_w    = (width > 1) ? $clog2(width) : 1;
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(width - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  p2s_state_t         r_state, w_state_nxt;
  logic [width-1:0]   r_shifter, w_shifter_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [width-1:0]   r_hold_data, w_hold_data_nxt;
  logic               r_hold_valid, w_hold_valid_nxt;
  logic               r_ready;

  logic w_accept;
  logic w_xfer;
  logic w_at_last;
  logic w_last_xfer;

  assign w_accept    = parallel_valid & r_ready;
  assign w_xfer      = (r_state == SHIFT) & serial_ready;
  // Explicit compare against width-1 so non-power-of-two widths wrap correctly.
  assign w_at_last   = (r_cnt == c_last_idx);
  assign w_last_xfer = w_xfer & w_at_last;

  always_comb begin
    w_state_nxt      = r_state;
    w_shifter_nxt    = r_shifter;
    w_cnt_nxt        = r_cnt;
    w_hold_data_nxt  = r_hold_data;
    w_hold_valid_nxt = r_hold_valid;

    case (r_state)
      IDLE: begin
        // Holding register is always empty here, so an accepted word goes
        // straight into the shifter.
        if (w_accept) begin
          w_shifter_nxt = parallel_data;
          w_cnt_nxt     = '0;
          w_state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (w_last_xfer) begin
          w_cnt_nxt = '0;
          if (r_hold_valid) begin
            // parallel_ready is low while the hold is full, so no accept
            // can collide with this reload.
            w_shifter_nxt    = r_hold_data;
            w_hold_valid_nxt = 1'b0;
          end else if (w_accept) begin
            w_shifter_nxt = parallel_data;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_xfer) begin
            w_shifter_nxt = {1'b0, r_shifter[width-1:1]};
            w_cnt_nxt     = r_cnt + c_cnt_one;
          end
          if (w_accept) begin
            w_hold_data_nxt  = parallel_data;
            w_hold_valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shifter    <= '0;
      r_cnt        <= '0;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shifter    <= w_shifter_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold_data  <= w_hold_data_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      // Ready tracks the hold flag one cycle ahead so it is a clean flop.
      r_ready      <= ~w_hold_valid_nxt;
    end
  end

  assign parallel_ready = r_ready;
  assign serial_valid   = (r_state == SHIFT);
  // Gated so a stale shifter bit never appears while idle.
  assign serial_data    = serial_valid & r_shifter[0];
  assign serial_last    = serial_valid & w_at_last;
  assign busy           = serial_valid | r_hold_valid;

endmodule : parallel_to_serial
`default_nettype wire

// File: tb/tb_parallel_to_serial.sv
`default_nettype none
// ============================================================================
//  Module    : tb_parallel_to_serial
//  Purpose   : Self-checking bench for parallel_to_serial. A width=8 instance
//              is checked against a bit-queue reference model; a width=5
//              instance is looped into a behavioural deserializer.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_parallel_to_serial;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic       pv = 1'b0;
  logic [7:0] pd = '0;
  logic       sr = 1'b0;
  logic       pr, sv, sd, sl, bz;

  logic       pv5 = 1'b0;
  logic [4:0] pd5 = '0;
  logic       sr5 = 1'b0;
  logic       pr5, sv5, sd5, sl5, bz5;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {last, bit} entries still to be sent, the
  // number of words in flight, and the expected registered ready.
  logic [1:0] mq[$];
  int         m_words = 0;
  logic       m_ready = 1'b0;

  // Loopback bookkeeping for the width=5 instance.
  logic [4:0] tx_q[$];
  logic [4:0] rx_q[$];
  logic [4:0] rx_word = '0;
  int         rx_bits = 0;

  parallel_to_serial #(.width(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .parallel_valid (pv),
    .parallel_data  (pd),
    .parallel_ready (pr),
    .serial_valid   (sv),
    .serial_data    (sd),
    .serial_last    (sl),
    .serial_ready   (sr),
    .busy           (bz)
  );

  parallel_to_serial #(.width(5)) dut5 (
    .clk            (clk),
    .rst_n          (rst_n),
    .parallel_valid (pv5),
    .parallel_data  (pd5),
    .parallel_ready (pr5),
    .serial_valid   (sv5),
    .serial_data    (sd5),
    .serial_last    (sl5),
    .serial_ready   (sr5),
    .busy           (bz5)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    m_words = 0;
    m_ready = 1'b0;
    rx_bits = 0;
    rx_word = '0;
  endtask

  // Advance one clock: evaluate handshakes from the pre-edge inputs, update
  // the model after the edge, and return 1 time unit past the edge.
  task automatic tick();
    logic       acc, xfr;
    logic [1:0] e;
    logic [7:0] w;
    acc = rst_n && pv && m_ready;
    xfr = rst_n && (mq.size() > 0) && sr;
    w   = pd;
    if (rst_n && pv5 && pr5) tx_q.push_back(pd5);
    if (rst_n && sv5 && sr5) begin
      if (rx_bits < 5) rx_word[rx_bits] = sd5;
      rx_bits++;
      if (sl5) begin
        rx_q.push_back(rx_word);
        rx_bits = 0;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (xfr) begin
        e = mq.pop_front();
        if (e[1]) m_words--;
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) mq.push_back({(i == 7), w[i]});
        m_words++;
      end
      m_ready = (m_words < 2);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sv, sd, sl, bz, pr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {sv, sd, sl, bz, pr});
    end
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (pr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_before_edge: got %b expected 0", pr);
    end
    tick();
    checks++;
    if ({pr, sv, bz} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ready_after_edge: got %b expected 100", {pr, sv, bz});
    end
  endtask

  task automatic test_single_a5();
    logic [7:0] w;
    w  = 8'hA5;
    pv = 1'b1;
    pd = w;
    sr = 1'b1;
    tick();
    pv = 1'b0;
    pd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({sv, sd, sl} !== {1'b1, w[i], (i == 7)}) begin
        errors++;
        $display("FAIL a5_bit%0d: got v/d/l=%b expected %b", i, {sv, sd, sl},
                 {1'b1, w[i], (i == 7)});
      end
      tick();
    end
    checks++;
    if ({sv, bz} !== 2'b00) begin
      errors++;
      $display("FAIL a5_idle_after: got v/busy=%b expected 00", {sv, bz});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w16;
    logic        exp_pr;
    w16 = {8'hFF, 8'h3C};
    pv  = 1'b1;
    pd  = 8'h3C;
    sr  = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp_pr = !(i >= 1 && i <= 7);
      checks++;
      if ({sv, sd, sl, pr} !== {1'b1, w16[i], (i == 7 || i == 15), exp_pr}) begin
        errors++;
        $display("FAIL b2b_bit%0d: got v/d/l/rdy=%b expected %b", i, {sv, sd, sl, pr},
                 {1'b1, w16[i], (i == 7 || i == 15), exp_pr});
      end
      if (i == 0) pd = 8'hFF;
      else        pv = 1'b0;
      tick();
    end
    checks++;
    if (sv !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_after: got %b expected 0", sv);
    end
  endtask

  task automatic test_stall();
    logic [7:0] dec;
    int         nxfer;
    logic       prev_stall;
    logic       prev_d, prev_l;
    dec        = '0;
    nxfer      = 0;
    prev_stall = 1'b0;
    prev_d     = 1'b0;
    prev_l     = 1'b0;
    pv = 1'b1;
    pd = 8'h81;
    sr = 1'b0;
    tick();
    pv = 1'b0;
    pd = 8'h00;
    for (int k = 0; k < 60 && nxfer < 8; k++) begin
      sr = (k % 3 == 0);
      checks++;
      if (sv !== 1'b1) begin
        errors++;
        $display("FAIL stall_valid cycle %0d: got %b expected 1", k, sv);
      end
      if (prev_stall) begin
        checks++;
        if ({sd, sl} !== {prev_d, prev_l}) begin
          errors++;
          $display("FAIL stall_hold cycle %0d: got d/l=%b expected %b", k, {sd, sl},
                   {prev_d, prev_l});
        end
      end
      if (sr && sv) begin
        if (nxfer < 8) dec[nxfer] = sd;
        nxfer++;
      end
      prev_stall = sv && !sr;
      prev_d     = sd;
      prev_l     = sl;
      tick();
    end
    checks++;
    if (dec !== 8'h81 || nxfer != 8) begin
      errors++;
      $display("FAIL stall_word: got %h after %0d transfers expected 81 after 8", dec, nxfer);
    end
    checks++;
    if (sv !== 1'b0) begin
      errors++;
      $display("FAIL stall_extra_bits: got valid %b expected 0", sv);
    end
    sr = 1'b1;
  endtask

  task automatic test_reset_midword();
    logic [7:0] w;
    pv = 1'b1;
    pd = 8'hF0;
    sr = 1'b1;
    tick();
    pd = 8'h0F;
    tick();
    pv = 1'b0;
    pd = 8'h00;
    tick();
    tick();
    checks++;
    if ({sv, pr, bz} !== 3'b101) begin
      errors++;
      $display("FAIL midword_pre_reset: got v/rdy/busy=%b expected 101", {sv, pr, bz});
    end
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({sv, sd, sl, bz, pr} !== 5'b0) begin
      errors++;
      $display("FAIL midword_async_reset: got %b expected 00000", {sv, sd, sl, bz, pr});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    w  = 8'h55;
    pv = 1'b1;
    pd = w;
    checks++;
    if ({pr, sv} !== 2'b10) begin
      errors++;
      $display("FAIL midword_after_release: got rdy/v=%b expected 10", {pr, sv});
    end
    tick();
    pv = 1'b0;
    pd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({sv, sd, sl} !== {1'b1, w[i], (i == 7)}) begin
        errors++;
        $display("FAIL midword_55_bit%0d: got v/d/l=%b expected %b", i, {sv, sd, sl},
                 {1'b1, w[i], (i == 7)});
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sv, bz} !== 2'b00) begin
        errors++;
        $display("FAIL midword_no_leftover %0d: got v/busy=%b expected 00", i, {sv, bz});
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic exp_v;
    for (int c = 0; c < 400; c++) begin
      pv = ($urandom_range(0, 1) == 1);
      pd = 8'($urandom);
      sr = ($urandom_range(0, 3) != 0);
      tick();
      exp_v = (mq.size() > 0);
      checks++;
      if ({pr, sv, bz} !== {m_ready, exp_v, (m_words > 0)}) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d: got rdy/v/busy=%b expected %b", c,
                 {pr, sv, bz}, {m_ready, exp_v, (m_words > 0)});
      end
      if (exp_v) begin
        checks++;
        if ({sd, sl} !== {mq[0][0], mq[0][1]}) begin
          errors++;
          $display("FAIL rand_data cycle %0d: got d/l=%b expected %b", c, {sd, sl},
                   {mq[0][0], mq[0][1]});
        end
      end
    end
    pv = 1'b0;
    sr = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if ({sv, bz} !== 2'b00) begin
      errors++;
      $display("FAIL rand_drain: got v/busy=%b expected 00", {sv, bz});
    end
  endtask

  task automatic test_loopback_w5();
    int n;
    tx_q.delete();
    rx_q.delete();
    rx_bits = 0;
    for (int c = 0; c < 40000 && rx_q.size() < 1000; c++) begin
      if (tx_q.size() < 1000) begin
        pv5 = ($urandom_range(0, 3) != 0);
        pd5 = 5'($urandom);
      end else begin
        pv5 = 1'b0;
      end
      sr5 = ($urandom_range(0, 3) != 0);
      tick();
    end
    pv5 = 1'b0;
    sr5 = 1'b0;
    checks++;
    if (rx_q.size() != 1000 || tx_q.size() != 1000) begin
      errors++;
      $display("FAIL loop_count: got rx %0d tx %0d expected 1000 each",
               rx_q.size(), tx_q.size());
    end
    n = (rx_q.size() < tx_q.size()) ? rx_q.size() : tx_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== tx_q[i]) begin
        errors++;
        $display("FAIL loop_word %0d: got %h expected %h", i, rx_q[i], tx_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_stall();
    test_reset_midword();
    test_random();
    test_loopback_w5();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_parallel_to_serial
`default_nettype wire
